// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Runs the host request sequence on the
// open-drain keyboard lines: clock inhibit, start bit, 8 data bits
// (LSB first), odd parity, stop bit, then checks the device ACK. Holds the
// companion receiver off via rx_inhibit_o while it owns the bus.
//
// Ports:
//   core_clk_i, core_rst_ni        clock, async active-low reset
//   tx_valid_i, tx_data_i          command byte request (taken when ready)
//   tx_ready_o                     high only in idle
//   tx_done_o                      one-cycle pulse at the end of a transfer
//   tx_ack_err_o, tx_timeout_o     status, valid with tx_done_o, held after
//   rx_inhibit_o                   high whenever not idle
//   kbd_clk_in_i, kbd_data_in_i    asynchronous PS/2 pin samples
//   kbd_clk_oe_o, kbd_data_oe_o    1 = pull line low, 0 = release
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       core_clk_i,
  input  logic       core_rst_ni,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_ack_err_o,
  output logic       tx_timeout_o,
  output logic       rx_inhibit_o,
  input  logic       kbd_clk_in_i,
  input  logic       kbd_data_in_i,
  output logic       kbd_clk_oe_o,
  output logic       kbd_data_oe_o
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StShift, StAck, StWaitIdle, StDone
  } state_e;

  state_e               state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                 clk_prev_q;
  logic [InhW-1:0]      inh_cnt_q;
  logic [ToW-1:0]       to_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [8:0]           shift_q;  // {parity, data}, shifted out LSB first
  logic                 clk_oe_q, data_oe_q;
  logic                 ready_q, done_q, ack_err_q, timeout_q, rx_inh_q;

  logic           clk_s, data_s, fall, to_hit;
  logic [ToW-1:0] to_cnt_inc;

  // Idle lines float high, so the synchronizers reset to 1 to avoid a
  // phantom falling edge right after reset.
  always_ff @(posedge core_clk_i or negedge core_rst_ni) begin
    if (!core_rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kbd_clk_in_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kbd_data_in_i};
      clk_prev_q  <= clk_s;
    end
  end

  always_comb begin
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    data_s     = data_sync_q[SYNC_STAGES-1];
    fall       = clk_prev_q & ~clk_s;
    // An edge in the expiry cycle wins over the timeout.
    to_hit     = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) && !fall;
    to_cnt_inc = (to_cnt_q == ToW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + 1'b1;
  end

  always_ff @(posedge core_clk_i or negedge core_rst_ni) begin
    if (!core_rst_ni) begin
      state_q   <= StIdle;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      rx_inh_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      // Saturating, cleared on every device clock fall.
      to_cnt_q <= fall ? '0 : to_cnt_inc;
      unique case (state_q)
        StIdle: begin
          if (tx_valid_i && ready_q) begin
            shift_q   <= {~^tx_data_i, tx_data_i};
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b1;
            ready_q   <= 1'b0;
            rx_inh_q  <= 1'b1;
            state_q   <= StInhibit;
          end
        end
        StInhibit: begin
          if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
            data_oe_q <= 1'b1;  // start bit
            state_q   <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        StReq: begin
          clk_oe_q  <= 1'b0;
          to_cnt_q  <= '0;
          bit_cnt_q <= '0;
          state_q   <= StShift;
        end
        StShift, StAck, StWaitIdle: begin
          if (to_hit) begin
            data_oe_q <= 1'b0;
            timeout_q <= 1'b1;
            ack_err_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else if (state_q == StShift) begin
            if (fall) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) begin
                data_oe_q <= 1'b0;  // stop bit: release the line
                state_q   <= StAck;
              end else begin
                data_oe_q <= ~shift_q[0];
                shift_q   <= {1'b0, shift_q[8:1]};
              end
            end
          end else if (state_q == StAck) begin
            if (fall) begin
              ack_err_q <= data_s;  // device pulls data low to ACK
              state_q   <= StWaitIdle;
            end
          end else if (clk_s && data_s) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          ready_q  <= 1'b1;
          rx_inh_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready_o    = ready_q;
  assign tx_done_o     = done_q;
  assign tx_ack_err_o  = ack_err_q;
  assign tx_timeout_o  = timeout_q;
  assign rx_inhibit_o  = rx_inh_q;
  assign kbd_clk_oe_o  = clk_oe_q;
  assign kbd_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned InhibitCycles = 20;
  localparam int unsigned TimeoutCycles = 200;
  localparam int unsigned HalfPeriod    = 20;
  localparam int unsigned SyncLatency   = 3;  // pin edge to acted-on edge

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit;
  logic       kbd_clk_oe, kbd_data_oe;
  logic       kbd_clk_in, kbd_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign kbd_clk_in  = ~(kbd_clk_oe | dev_clk_low);
  assign kbd_data_in = ~(kbd_data_oe | dev_data_low);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_fall_cyc = 0;
  int frame_viol = 0;
  bit in_frame = 1'b0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .SYNC_STAGES   (2)
  ) dut (
    .core_clk_i   (clk),
    .core_rst_ni  (rst_n),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready),
    .tx_done_o    (tx_done),
    .tx_ack_err_o (tx_ack_err),
    .tx_timeout_o (tx_timeout),
    .rx_inhibit_o (rx_inhibit),
    .kbd_clk_in_i (kbd_clk_in),
    .kbd_data_in_i(kbd_data_in),
    .kbd_clk_oe_o (kbd_clk_oe),
    .kbd_data_oe_o(kbd_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (in_frame && (tx_ready || !rx_inhibit)) frame_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1 tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    in_frame = 1'b1;
  endtask

  // Device side: waits for the host request, then generates nclk clock
  // pulses, sampling host data just before each rising edge.
  task automatic dev_xfer(input int nclk, input bit ack, output logic [10:0] frame,
                          output int inh_len);
    int t;
    frame = '0;
    t = 0;
    while (kbd_clk_in !== 1'b0 && t < 1000) begin
      @(posedge clk); #1 t++;
    end
    check_eq("dev_req_seen", (t < 1000), 1);
    inh_len = 0;
    while (kbd_clk_in === 1'b0 && inh_len < 1000) begin
      @(posedge clk); #1 inh_len++;
    end
    frame[0] = kbd_data_in;
    for (int i = 1; i <= nclk; i++) begin
      repeat (HalfPeriod) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (HalfPeriod) @(posedge clk);
      #1 if (i <= 10) frame[i] = kbd_data_in;
      dev_clk_low = 1'b0;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == 11) dev_data_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit exp_ack, input bit exp_to);
    int t;
    t = 0;
    @(negedge clk);
    while (tx_done !== 1'b1 && t < 3000) begin
      @(negedge clk); t++;
    end
    done_cyc = cyc;
    check_eq({tag, "_done"}, tx_done, 1);
    check_eq({tag, "_ack_err"}, tx_ack_err, exp_ack);
    check_eq({tag, "_timeout"}, tx_timeout, exp_to);
    check_eq({tag, "_ready_at_done"}, tx_ready, 0);
    check_eq({tag, "_oe_at_done"}, {kbd_clk_oe, kbd_data_oe}, 0);
    in_frame = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_after"}, tx_ready, 1);
    check_eq({tag, "_done_one_cycle"}, tx_done, 0);
    check_eq({tag, "_rx_inh_after"}, rx_inhibit, 0);
  endtask

  logic [7:0]  vec_byte [4] = '{8'hED, 8'h01, 8'h00, 8'hFF};
  logic        vec_par  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [10:0] fr;
    int il;
    int d0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", tx_ready, 1);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_flags", {tx_ack_err, tx_timeout}, 0);
    check_eq("rst_rx_inh", rx_inhibit, 0);
    check_eq("rst_oe", {kbd_clk_oe, kbd_data_oe}, 0);
    rst_n = 1'b1;

    // Normal frames with ACK; the first also checks the inhibit length
    for (int v = 0; v < 4; v++) begin
      send(vec_byte[v]);
      dev_xfer(11, 1'b1, fr, il);
      if (v == 0) check_eq("inhibit_plus_req_len", il, InhibitCycles + 1);
      check_eq($sformatf("frame_%02h", vec_byte[v]), fr,
               {1'b1, vec_par[v], vec_byte[v], 1'b0});
      wait_done($sformatf("ok_%02h", vec_byte[v]), 1'b0, 1'b0);
    end

    // NACK
    send(8'hED);
    dev_xfer(11, 1'b0, fr, il);
    check_eq("nack_frame", fr, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_done("nack", 1'b1, 1'b0);

    // Device stops clocking after four falls
    send(8'hED);
    dev_xfer(4, 1'b1, fr, il);
    wait_done("tmo", 1'b0, 1'b1);
    check_eq("tmo_latency", done_cyc - last_fall_cyc, TimeoutCycles + SyncLatency);

    // tx_valid mid-frame must be ignored
    frame_viol = 0;
    send(8'hF4);
    fork
      dev_xfer(11, 1'b1, fr, il);
      begin
        repeat (150) @(posedge clk);
        #1 tx_data = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    check_eq("ignore_frame", fr, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done("ignore", 1'b0, 1'b0);
    check_eq("ignore_ready_inh", frame_viol, 0);
    d0 = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    check_eq("ignore_no_queue_done", done_cnt, d0);
    check_eq("ignore_no_queue_clk", kbd_clk_oe, 0);

    // Reset during inhibit
    send(8'h12);
    repeat (8) @(posedge clk);
    #1 check_eq("inh_clk_low", kbd_clk_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_inh_oe", {kbd_clk_oe, kbd_data_oe}, 0);
    check_eq("rst_inh_ready", tx_ready, 1);
    check_eq("rst_inh_rx_inh", rx_inhibit, 0);
    in_frame = 1'b0;
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-shift
    send(8'h00);
    dev_xfer(5, 1'b1, fr, il);
    check_eq("shift_data_low", kbd_data_oe, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_shift_oe", {kbd_clk_oe, kbd_data_oe}, 0);
    in_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (TimeoutCycles + 50) @(posedge clk);
    #1;
    check_eq("rst_no_done", done_cnt, d0);
    check_eq("rst_ready_after", tx_ready, 1);

    // Clean transfer after reset
    send(8'hF4);
    dev_xfer(11, 1'b1, fr, il);
    check_eq("post_rst_frame", fr, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done("post_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1);
  end

endmodule
